// File: rtl/crc32_frame_chk.sv
`timescale 1ns/1ps
// crc32_frame_chk
//   Multi-byte-per-cycle Ethernet CRC-32 frame checker for the MAC receive path.
//   It keeps a running CRC per frame and produces one registered verdict per
//   frame. The verdict reports a good or bad FCS residue, a runt, or an abort.
//
//   Ports
//     clk, reset                  clock, asynchronous active-high reset
//     in_valid/in_sof/in_eof      beat qualifier and frame delimiters
//     in_data                     beat data, byte 0 = in_data[7:0] (first on wire)
//     in_nbytes                   valid byte count on an eof beat (1..DATA_BYTES)
//     crc_value                   running CRC register
//     res_valid                   one-cycle verdict strobe
//     res_ok/res_runt/res_abort   verdict flags, held until the next verdict
//     stats_clr                   synchronous clear of the statistics counters
//     frame_cnt/err_cnt           frames with a verdict / frames with res_ok=0
//
//   Optional feature
//     CRC_CHK_STATS_EN   When defined, this builds the saturating frame and
//                        error counters. When undefined, the counters read 0
//                        and stats_clr is ignored.
module crc32_frame_chk #(
   parameter int unsigned DATA_BYTES = 1,
   parameter int unsigned MIN_BYTES  = 64,
   parameter int unsigned CNT_W      = 16
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              in_valid,
   input  logic                              in_sof,
   input  logic                              in_eof,
   input  logic [8*DATA_BYTES-1:0]           in_data,
   input  logic [$clog2(DATA_BYTES+1)-1:0]   in_nbytes,
   output logic [31:0]                       crc_value,
   output logic                              res_valid,
   output logic                              res_ok,
   output logic                              res_runt,
   output logic                              res_abort,
   input  logic                              stats_clr,
   output logic [CNT_W-1:0]                  frame_cnt,
   output logic [CNT_W-1:0]                  err_cnt
);

   localparam int unsigned NB_W    = $clog2(DATA_BYTES+1);
   localparam logic [31:0] POLY    = 32'h04C11DB7;
   localparam logic [31:0] RESIDUE = 32'hC704DD7B;
   localparam logic [15:0] MIN_LEN = 16'(MIN_BYTES);
   localparam logic        RUNT_EN = (MIN_BYTES != 0);

   localparam logic [0:0] ST_IDLE     = 1'b0;
   localparam logic [0:0] ST_IN_FRAME = 1'b1;

   // The register is kept MSB-first while each data byte enters LSB-first.
   // This is the Ethernet bit order, so a good frame leaves 0xC704DD7B.
   function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] d);
      logic [31:0] r;
      r = c;
      for (int unsigned b = 0; b < 8; b++) begin
         if (r[31] ^ d[b]) r = {r[30:0], 1'b0} ^ POLY;
         else              r = {r[30:0], 1'b0};
      end
      return r;
   endfunction

   logic [0:0]  state_q, state_d;
   logic [31:0] crc_q, crc_d;
   logic [15:0] cnt_q, cnt_d;
   logic        res_valid_q, res_valid_d;
   logic        res_ok_q, res_ok_d;
   logic        res_runt_q, res_runt_d;
   logic        res_abort_q, res_abort_d;

   logic            in_frame, accept, abort, finish;
   logic [NB_W-1:0] nfold;
   logic [31:0]     crc_fold;
   logic [15:0]     cnt_base, cnt_fold;
   logic [16:0]     cnt_sum;

   always_comb begin
      in_frame = (state_q == ST_IN_FRAME);
      accept   = in_valid & (in_sof | in_frame);
      abort    = in_valid & in_sof & in_frame;
      finish   = accept & in_eof;
      nfold    = in_eof ? in_nbytes : NB_W'(DATA_BYTES);

      // Bytes are chained in wire order. Bytes past nfold are skipped.
      crc_fold = in_sof ? '1 : crc_q;
      for (int unsigned i = 0; i < DATA_BYTES; i++) begin
         if (i < 32'(nfold)) crc_fold = crc_byte(crc_fold, in_data[8*i +: 8]);
      end

      cnt_base = in_sof ? '0 : cnt_q;
      cnt_sum  = {1'b0, cnt_base} + 17'(nfold);
      cnt_fold = cnt_sum[16] ? '1 : cnt_sum[15:0];

      state_d     = state_q;
      crc_d       = crc_q;
      cnt_d       = cnt_q;
      res_valid_d = 1'b0;
      res_ok_d    = res_ok_q;
      res_runt_d  = res_runt_q;
      res_abort_d = res_abort_q;

      if (accept) begin
         crc_d   = crc_fold;
         cnt_d   = cnt_fold;
         state_d = in_eof ? ST_IDLE : ST_IN_FRAME;
      end

      // An abort reports on the old frame, so its length comes from cnt_q.
      // If the restarting beat also carries eof, the abort takes the strobe.
      // In that case the one-beat frame gets no verdict of its own.
      if (abort) begin
         res_valid_d = 1'b1;
         res_abort_d = 1'b1;
         res_ok_d    = 1'b0;
         res_runt_d  = RUNT_EN & (cnt_q < MIN_LEN);
      end else if (finish) begin
         res_valid_d = 1'b1;
         res_abort_d = 1'b0;
         res_runt_d  = RUNT_EN & (cnt_fold < MIN_LEN);
         res_ok_d    = (crc_fold == RESIDUE) & ~res_runt_d;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         crc_q       <= '1;
         cnt_q       <= '0;
         res_valid_q <= 1'b0;
         res_ok_q    <= 1'b0;
         res_runt_q  <= 1'b0;
         res_abort_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         crc_q       <= crc_d;
         cnt_q       <= cnt_d;
         res_valid_q <= res_valid_d;
         res_ok_q    <= res_ok_d;
         res_runt_q  <= res_runt_d;
         res_abort_q <= res_abort_d;
      end
   end

   assign crc_value = crc_q;
   assign res_valid = res_valid_q;
   assign res_ok    = res_ok_q;
   assign res_runt  = res_runt_q;
   assign res_abort = res_abort_q;

`ifdef CRC_CHK_STATS_EN
   logic [CNT_W-1:0] frame_cnt_q, err_cnt_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         frame_cnt_q <= '0;
         err_cnt_q   <= '0;
      end else if (stats_clr) begin
         frame_cnt_q <= '0;
         err_cnt_q   <= '0;
      end else if (res_valid_q) begin
         if (frame_cnt_q != '1) frame_cnt_q <= frame_cnt_q + CNT_W'(1);
         if (!res_ok_q && err_cnt_q != '1) err_cnt_q <= err_cnt_q + CNT_W'(1);
      end
   end

   assign frame_cnt = frame_cnt_q;
   assign err_cnt   = err_cnt_q;
`else
   logic unused_stats_clr;
   assign unused_stats_clr = stats_clr;
   assign frame_cnt        = '0;
   assign err_cnt          = '0;
`endif

endmodule

// File: tb/tb_crc32_frame_chk.sv
`timescale 1ns/1ps
// Testbench for crc32_frame_chk.
//   dut   : DATA_BYTES=4, MIN_BYTES=64 (main scenarios)
//   dut8  : DATA_BYTES=8, MIN_BYTES=0  (check-string scenario)
//   Expected values come from a reflected, table-free CRC-32 model that works
//   on whole byte queues.
module tb_crc32_frame_chk;

   localparam int DB   = 4;
   localparam int MINB = 64;
   localparam int CW   = 16;

   typedef logic [7:0] bq_t[$];

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          reset, stats_clr;
   logic          in_valid, in_sof, in_eof;
   logic [8*DB-1:0] in_data;
   logic [2:0]    in_nbytes;
   logic [31:0]   crc_value;
   logic          res_valid, res_ok, res_runt, res_abort;
   logic [CW-1:0] frame_cnt, err_cnt;

   logic          v8, sof8, eof8;
   logic [63:0]   data8;
   logic [3:0]    nb8;
   logic [31:0]   crc8;
   logic          rv8, ok8, runt8, ab8;
   logic [CW-1:0] fc8, ec8;

   crc32_frame_chk #(.DATA_BYTES(DB), .MIN_BYTES(MINB), .CNT_W(CW)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_sof(in_sof), .in_eof(in_eof),
      .in_data(in_data), .in_nbytes(in_nbytes), .crc_value(crc_value),
      .res_valid(res_valid), .res_ok(res_ok), .res_runt(res_runt), .res_abort(res_abort),
      .stats_clr(stats_clr), .frame_cnt(frame_cnt), .err_cnt(err_cnt));

   crc32_frame_chk #(.DATA_BYTES(8), .MIN_BYTES(0), .CNT_W(CW)) dut8 (
      .clk(clk), .reset(reset), .in_valid(v8), .in_sof(sof8), .in_eof(eof8),
      .in_data(data8), .in_nbytes(nb8), .crc_value(crc8),
      .res_valid(rv8), .res_ok(ok8), .res_runt(runt8), .res_abort(ab8),
      .stats_clr(stats_clr), .frame_cnt(fc8), .err_cnt(ec8));

   int n_chk  = 0;
   int n_pass = 0;
   int exp_frames = 0;
   int exp_errs   = 0;

   // Reference model: LSB-first CRC-32, reflected polynomial, no final inversion.
   function automatic logic [31:0] crc_ref(input bq_t q);
      logic [31:0] c;
      c = 32'hFFFFFFFF;
      foreach (q[i]) begin
         c = c ^ {24'h0, q[i]};
         for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
      end
      return c;
   endfunction

   function automatic logic [31:0] bitrev(input logic [31:0] c);
      logic [31:0] r;
      for (int i = 0; i < 32; i++) r[i] = c[31-i];
      return r;
   endfunction

   function automatic bq_t make_frame(input int plen, input bit bad);
      bq_t q;
      logic [31:0] fcs;
      q = {};
      for (int i = 0; i < plen; i++) q.push_back(8'($urandom));
      fcs = ~crc_ref(q);
      for (int i = 0; i < 4; i++) q.push_back(8'(fcs >> (8*i)));
      if (bad) q[10] = q[10] ^ 8'h01;
      return q;
   endfunction

   function automatic logic [CW-1:0] exp_cnt(input int n);
`ifdef CRC_CHK_STATS_EN
      return CW'(n);
`else
      return (n == -1) ? '1 : '0;
`endif
   endfunction

   // Drives one frame, or its first stop_beats beats when stop_beats != 0.
   // It returns #1 after the last beat's edge with in_valid low, so a following
   // call continues back-to-back.
   task automatic send_frame(input bq_t q, input int gap_pct, input int stop_beats,
                             input bit expect_abort, input int prev_len);
      int nbeats, last, rem;
      logic [31:0] model;
      logic eok, erunt;
      nbeats = (q.size() + DB - 1) / DB;
      last   = (stop_beats != 0) ? stop_beats : nbeats;
      for (int b = 0; b < last; b++) begin
         for (int k = 0; k < DB; k++)
            in_data[8*k +: 8] = (b*DB + k < q.size()) ? q[b*DB + k] : 8'($urandom);
         in_valid = 1'b1;
         in_sof   = (b == 0);
         in_eof   = (stop_beats == 0) && (b == nbeats - 1);
         rem      = q.size() - b*DB;
         in_nbytes = in_eof ? 3'(rem) : 3'($urandom_range(0, DB));
         @(posedge clk); #1;
         in_valid = 1'b0; in_sof = 1'b0; in_eof = 1'b0;
         if (b == 0 && expect_abort) begin
            n_chk++;
            if (res_valid !== 1'b1 || res_abort !== 1'b1 || res_ok !== 1'b0 ||
                res_runt !== (prev_len < MINB))
               $display("FAIL abort_verdict: got v=%b ab=%b ok=%b runt=%b want 1 1 0 %b",
                        res_valid, res_abort, res_ok, res_runt, prev_len < MINB);
            else n_pass++;
            exp_frames++; exp_errs++;
         end else if (b != last - 1 || stop_beats != 0) begin
            n_chk++;
            if (res_valid !== 1'b0) $display("FAIL no_early_verdict: got res_valid=%b want 0", res_valid);
            else n_pass++;
         end
         if (b != last - 1 && $urandom_range(99) < gap_pct) begin
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
         end
      end
      if (stop_beats == 0) begin
         model = crc_ref(q);
         erunt = (q.size() < MINB);
         eok   = (model == 32'hDEBB20E3) && !erunt;
         n_chk++;
         if (res_valid !== 1'b1 || res_ok !== eok || res_runt !== erunt || res_abort !== 1'b0)
            $display("FAIL verdict: len=%0d got v=%b ok=%b runt=%b ab=%b want 1 %b %b 0",
                     q.size(), res_valid, res_ok, res_runt, res_abort, eok, erunt);
         else n_pass++;
         n_chk++;
         if (crc_value !== bitrev(model))
            $display("FAIL crc_value: got %h want %h", crc_value, bitrev(model));
         else n_pass++;
         exp_frames++;
         if (!eok) exp_errs++;
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check_counters(input string tag);
      n_chk++;
      if (frame_cnt !== exp_cnt(exp_frames) || err_cnt !== exp_cnt(exp_errs))
         $display("FAIL counters_%s: got frame=%0d err=%0d want %0d %0d", tag,
                  frame_cnt, err_cnt, exp_cnt(exp_frames), exp_cnt(exp_errs));
      else n_pass++;
   endtask

   task automatic test_reset();
      n_chk++;
      if (crc_value !== 32'hFFFFFFFF || res_valid !== 1'b0 || res_ok !== 1'b0 ||
          res_runt !== 1'b0 || res_abort !== 1'b0 || frame_cnt !== '0 || err_cnt !== '0)
         $display("FAIL reset_state: got crc=%h v=%b ok=%b runt=%b ab=%b fc=%0d ec=%0d want ffffffff 0 0 0 0 0 0",
                  crc_value, res_valid, res_ok, res_runt, res_abort, frame_cnt, err_cnt);
      else n_pass++;
   endtask

   task automatic test_check_string();
      bq_t s;
      s = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
            8'h26, 8'h39, 8'hF4, 8'hCB};
      // 13 bytes with MIN_BYTES=64: the residue is good but the frame is a runt.
      send_frame(s, 0, 0, 1'b0, 0);
      n_chk++;
      if (crc_value !== 32'hC704DD7B) $display("FAIL check_string_crc4: got %h want c704dd7b", crc_value);
      else n_pass++;
      idle(1);
      // The same stream on the 8-byte instance ends with a 5-byte eof beat.
      data8 = {s[7], s[6], s[5], s[4], s[3], s[2], s[1], s[0]};
      v8 = 1'b1; sof8 = 1'b1; eof8 = 1'b0; nb8 = 4'd8;
      @(posedge clk); #1;
      data8 = {24'($urandom), s[12], s[11], s[10], s[9], s[8]};
      sof8 = 1'b0; eof8 = 1'b1; nb8 = 4'd5;
      @(posedge clk); #1;
      v8 = 1'b0; eof8 = 1'b0;
      n_chk++;
      if (rv8 !== 1'b1 || ok8 !== 1'b1 || runt8 !== 1'b0 || ab8 !== 1'b0 || crc8 !== 32'hC704DD7B)
         $display("FAIL check_string_db8: got v=%b ok=%b runt=%b ab=%b crc=%h want 1 1 0 0 c704dd7b",
                  rv8, ok8, runt8, ab8, crc8);
      else n_pass++;
      idle(1);
   endtask

   task automatic test_good_bad_64();
      logic [31:0] held;
      send_frame(make_frame(60, 1'b0), 0, 0, 1'b0, 0);
      idle(1);
      n_chk++;
      if (res_valid !== 1'b0 || res_ok !== 1'b1)
         $display("FAIL pulse_and_hold: got v=%b ok=%b want 0 1", res_valid, res_ok);
      else n_pass++;
      // A beat without sof in IDLE must be dropped.
      held = crc_value;
      in_valid = 1'b1; in_data = 32'($urandom); in_nbytes = 3'd4;
      @(posedge clk); #1;
      in_valid = 1'b0;
      n_chk++;
      if (crc_value !== held || res_valid !== 1'b0)
         $display("FAIL idle_drop: got crc=%h v=%b want %h 0", crc_value, res_valid, held);
      else n_pass++;
      send_frame(make_frame(60, 1'b1), 0, 0, 1'b0, 0);
      idle(1);
      check_counters("good_bad");
   endtask

   task automatic test_runt_abort();
      send_frame(make_frame(56, 1'b0), 0, 0, 1'b0, 0);
      idle(1);
      send_frame(make_frame(60, 1'b0), 0, 8, 1'b0, 0);
      send_frame(make_frame(60, 1'b0), 0, 0, 1'b1, 32);
      idle(1);
      check_counters("runt_abort");
   endtask

   task automatic test_back_to_back();
      for (int f = 0; f < 24; f++) begin
         send_frame(make_frame($urandom_range(54, 96), $urandom_range(99) < 30), 25, 0, 1'b0, 0);
         if ($urandom_range(1) == 0) idle($urandom_range(1, 2));
      end
      idle(2);
      check_counters("b2b");
   endtask

   task automatic test_reset_mid_frame();
      send_frame(make_frame(60, 1'b0), 0, 5, 1'b0, 0);
      #2 reset = 1'b1;
      #1;
      exp_frames = 0; exp_errs = 0;
      n_chk++;
      if (crc_value !== 32'hFFFFFFFF || res_valid !== 1'b0 || frame_cnt !== '0 || err_cnt !== '0)
         $display("FAIL reset_mid: got crc=%h v=%b fc=%0d ec=%0d want ffffffff 0 0 0",
                  crc_value, res_valid, frame_cnt, err_cnt);
      else n_pass++;
      @(posedge clk); #1;
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         // Beats for the discarded frame are ignored because the checker is in IDLE.
         in_valid = 1'b1; in_data = 32'($urandom); in_nbytes = 3'd4; in_eof = (i == 3);
         @(posedge clk); #1;
         in_valid = 1'b0; in_eof = 1'b0;
         n_chk++;
         if (res_valid !== 1'b0 || crc_value !== 32'hFFFFFFFF)
            $display("FAIL post_reset_quiet: got v=%b crc=%h want 0 ffffffff", res_valid, crc_value);
         else n_pass++;
      end
      send_frame(make_frame(64, 1'b0), 0, 0, 1'b0, 0);
      idle(1);
      check_counters("after_reset");
   endtask

   task automatic test_stats_clr();
      stats_clr = 1'b1;
      @(posedge clk); #1;
      stats_clr = 1'b0;
      exp_frames = 0; exp_errs = 0;
      check_counters("clr");
      // When the clear coincides with a verdict strobe, the clear wins.
      send_frame(make_frame(60, 1'b1), 0, 0, 1'b0, 0);
      stats_clr = 1'b1;
      @(posedge clk); #1;
      stats_clr = 1'b0;
      exp_frames = 0; exp_errs = 0;
      check_counters("clr_wins");
   endtask

   initial begin
      reset = 1'b1; stats_clr = 1'b0;
      in_valid = 1'b0; in_sof = 1'b0; in_eof = 1'b0; in_data = '0; in_nbytes = '0;
      v8 = 1'b0; sof8 = 1'b0; eof8 = 1'b0; data8 = '0; nb8 = '0;
      repeat (3) @(posedge clk);
      #1;
      test_reset();
      reset = 1'b0;
      idle(1);
      test_reset();
      test_check_string();
      test_good_bad_64();
      test_runt_abort();
      test_back_to_back();
      test_reset_mid_frame();
      test_stats_clr();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/crc32_frame_chk.md
Name: crc32_frame_chk

Overview:
- Parametrised, multi-byte-per-cycle Ethernet CRC-32 frame checker for the GMII/MAC receive path.
- Consumes a beat stream of 1..8 bytes per clock with frame delimiters.
- Keeps a running CRC-32 per frame and emits a one-cycle registered verdict per frame: FCS residue good/bad, runt, abort.
- Sits after the MAC filter and before the loopback/drop decision; supersedes the byte-serial checker for wider datapaths.

Parameters:
- DATA_BYTES, 1, bytes per beat; legal values 1, 2, 4, 8.
- MIN_BYTES, 64, minimum legal frame length in bytes, FCS included; 0 disables the runt check.
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  beat qualifier.
- in_sof  in  1  first beat of frame; sampled only when in_valid=1.
- in_eof  in  1  last beat of frame; sampled only when in_valid=1.
- in_data  in  8*DATA_BYTES  beat data; byte 0 = in_data[7:0], processed first.
- in_nbytes  in  $clog2(DATA_BYTES+1)  valid byte count on an eof beat (1..DATA_BYTES); ignored on other beats, which are always full.
- crc_value  out  32  running CRC register.
- res_valid  out  1  one-cycle verdict strobe.
- res_ok  out  1  frame good; qualified by res_valid.
- res_runt  out  1  frame shorter than MIN_BYTES; qualified by res_valid.
- res_abort  out  1  frame terminated by a new sof; qualified by res_valid.
- stats_clr  in  1  synchronous clear of the counters.
- frame_cnt  out  CNT_W  frames with a verdict.
- err_cnt  out  CNT_W  frames with res_ok=0.

Behaviour:
- Reset: asynchronous, active-high. crc_value=32'hFFFFFFFF; res_valid, res_ok, res_runt, res_abort, frame_cnt, err_cnt all 0; FSM in IDLE; byte counter 0.
- CRC math: CRC-32, poly 0x04C11DB7, seed 0xFFFFFFFF, using the codebase's byte-wise next-state equations. Byte i of a beat is chained through byte i-1 combinationally; only the first in_nbytes bytes are folded on an eof beat. The result is registered, so crc_value updates one cycle after the beat. A frame is good when the final register equals 32'hC704DD7B.
- IDLE:
  - in_valid & in_sof: seed 0xFFFFFFFF, fold the beat, byte counter = bytes in the beat, go to IN_FRAME. If in_eof is also set, the frame is single-beat: verdict follows and the FSM stays in IDLE.
  - in_valid without sof: beat dropped; no CRC or counter change.
- IN_FRAME:
  - in_valid & ~sof & ~eof: fold the full beat, counter += DATA_BYTES. The counter saturates at all-ones (16-bit).
  - in_valid & eof: fold in_nbytes bytes, issue the verdict, go to IDLE.
  - in_valid & sof: abort the old frame (verdict with res_abort=1, res_ok=0), then restart on this beat as in IDLE.
  - in_valid=0: hold all state; gaps are unlimited.
- Verdict: res_valid pulses exactly one cycle, the cycle after the eof/abort beat.
  - res_runt = (MIN_BYTES!=0) & (bytes < MIN_BYTES).
  - res_ok = residue match & ~res_runt & ~res_abort.
  - Flags hold their value until the next verdict.
- Back-to-back frames: an eof beat followed immediately by a sof beat is legal; the verdict for frame N coincides with the folding of frame N+1 beat 0.
- crc_value after a verdict holds the final register until the next sof reseeds it.
- Reset asserted mid-frame: the frame is discarded with no verdict; all state returns to reset values.

Optional Feature:
- Macro: CRC_CHK_STATS_EN.
- Defined:
  - frame_cnt increments on every res_valid; err_cnt increments on res_valid & ~res_ok. Both saturate at all-ones.
  - stats_clr zeroes both. When stats_clr coincides with an increment, clear wins.
- Undefined: no counter flops; frame_cnt and err_cnt are tied to 0; stats_clr is ignored. Ports remain present.

Test Plan:
- DATA_BYTES=1, MIN_BYTES=0; bytes "123456789" then 0x26,0x39,0xF4,0xCB; sof on the first beat, eof on the last -> one cycle later res_valid=1, res_ok=1, crc_value=32'hC704DD7B.
- Same stream with DATA_BYTES=4, last beat in_nbytes=1 (13 bytes) -> identical verdict and crc_value as DATA_BYTES=1; repeat with DATA_BYTES=8, in_nbytes=5.
- 64-byte Ethernet frame with valid FCS, MIN_BYTES=64 -> res_ok=1. Flip bit 0 of byte 10 -> res_ok=0, err_cnt=1, frame_cnt=2 (STATS_EN).
- Valid 60-byte frame with MIN_BYTES=64 -> res_runt=1, res_ok=0; new sof at byte 32 of a frame -> res_abort=1 pulse, and the second frame's verdict is independent and correct.
- Back-to-back good frames with no idle cycle, in_valid gaps inserted mid-frame, and reset asserted mid-frame -> one verdict per completed frame only; after reset crc_value=32'hFFFFFFFF and counters are 0.
